simple_bus_xbar: RTL and testbench

- Single-cycle, pipelined N-host to M-device memory interconnect for the simple system. It connects the core data port to RAM, the simulation-control block and the timer.
- Fixed-priority host arbitration; combinational address decode against runtime base/mask pairs.
- Read data and error responses are routed back one cycle later using registered select state.
- Unmapped accesses complete with an error response.

---
 rtl/simple_bus_xbar_if.sv | 57 +++++
 rtl/simple_bus_xbar.sv | 152 +++++++++++++++
 tb/tb_simple_bus_xbar.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/simple_bus_xbar_if.sv
// -----------------------------------------------------------------------------
// simple_bus_xbar_if
// Bundles every host-side and device-side bus signal of simple_bus_xbar, plus
// the per-device address map (base/mask), into one interface.
//   slave  : crossbar view (takes host requests, drives device requests,
//            returns responses to hosts)
//   master : environment view (hosts, devices and address-map config)
// Signal names keep the _i/_o suffixes of the crossbar's own port list so the
// direction is read from the crossbar's point of view in both modports.
// -----------------------------------------------------------------------------
interface simple_bus_xbar_if #(
   parameter int unsigned NrDevices    = 1,
   parameter int unsigned NrHosts      = 1,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
);
   // host side
   logic [NrHosts-1:0]                     host_req_i;
   logic [NrHosts-1:0]                     host_gnt_o;
   logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i;
   logic [NrHosts-1:0]                     host_we_i;
   logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i;
   logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i;
   logic [NrHosts-1:0]                     host_rvalid_o;
   logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o;
   logic [NrHosts-1:0]                     host_err_o;

   // device side
   logic [NrDevices-1:0]                   device_req_o;
   logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
   logic [NrDevices-1:0]                   device_we_o;
   logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o;
   logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o;
   logic [NrDevices-1:0]                   device_rvalid_i;
   logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i;
   logic [NrDevices-1:0]                   device_err_i;

   // address map
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base;
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask;

   modport slave (
      input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      input  device_rvalid_i, device_rdata_i, device_err_i,
      input  cfg_device_addr_base, cfg_device_addr_mask,
      output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
   );

   modport master (
      output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      output device_rvalid_i, device_rdata_i, device_err_i,
      output cfg_device_addr_base, cfg_device_addr_mask,
      input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
   );
endinterface

// File: rtl/simple_bus_xbar.sv
// -----------------------------------------------------------------------------
// simple_bus_xbar
// Single-cycle, pipelined NrHosts x NrDevices memory interconnect.
//   - fixed-priority arbitration: lowest-index requesting host is granted in
//     the same cycle
//   - combinational decode against runtime base/mask pairs, lowest-index
//     matching device wins
//   - responses return exactly one cycle after the grant, steered by
//     registered select state; unmapped accesses complete with err=1, rdata=0
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : simple_bus_xbar_if.slave (host bus, device bus, address map)
// The interface instance must be built with the same parameter values.
// -----------------------------------------------------------------------------
module simple_bus_xbar #(
   parameter int unsigned NrDevices    = 1,
   parameter int unsigned NrHosts      = 1,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
) (
   input logic               clk_i,
   input logic               rst_ni,
   simple_bus_xbar_if.slave  bus
);

   localparam int unsigned HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
   localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   logic [HostIdxW-1:0]     hsel;
   logic                    grant;

   // Scanning from the top down leaves the lowest requesting index in hsel.
   always_comb begin
      hsel  = '0;
      grant = 1'b0;
      for (int h = NrHosts - 1; h >= 0; h--) begin
         if (bus.host_req_i[h]) begin
            hsel  = HostIdxW'(h);
            grant = 1'b1;
         end
      end
   end

   always_comb begin
      bus.host_gnt_o = '0;
      if (grant) begin
         bus.host_gnt_o[hsel] = 1'b1;
      end
   end

   // Selected host's request fields
   logic [AddressWidth-1:0] sel_addr;
   logic                    sel_we;
   logic [DataWidth/8-1:0]  sel_be;
   logic [DataWidth-1:0]    sel_wdata;

   assign sel_addr  = bus.host_addr_i[hsel];
   assign sel_we    = bus.host_we_i[hsel];
   assign sel_be    = bus.host_be_i[hsel];
   assign sel_wdata = bus.host_wdata_i[hsel];

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [DevIdxW-1:0]      dsel;
   logic                    mapped;

   always_comb begin
      dsel   = '0;
      mapped = 1'b0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((sel_addr & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d]) begin
            dsel   = DevIdxW'(d);
            mapped = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Request forwarding: payload is broadcast, only the decoded device sees req.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.device_req_o = '0;
      if (grant && mapped) begin
         bus.device_req_o[dsel] = 1'b1;
      end
   end

   always_comb begin
      bus.device_addr_o  = '0;
      bus.device_we_o    = '0;
      bus.device_be_o    = '0;
      bus.device_wdata_o = '0;
      for (int d = 0; d < NrDevices; d++) begin
         bus.device_addr_o[d]  = sel_addr;
         bus.device_we_o[d]    = sel_we;
         bus.device_be_o[d]    = sel_be;
         bus.device_wdata_o[d] = sel_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Response select state. Loaded unconditionally every cycle; resp_pending
   // qualifies everything, so host/dev/unmapped are only meaningful with it.
   // ---------------------------------------------------------------------------
   logic                    resp_pending;
   logic [HostIdxW-1:0]     resp_host;
   logic [DevIdxW-1:0]      resp_dev;
   logic                    resp_unmapped;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_pending  <= 1'b0;
         resp_host     <= '0;
         resp_dev      <= '0;
         resp_unmapped <= 1'b0;
      end else begin
         resp_pending  <= grant;
         resp_host     <= hsel;
         resp_dev      <= dsel;
         resp_unmapped <= ~mapped;
      end
   end

   // ---------------------------------------------------------------------------
   // Response routing. Unmapped accesses are answered by the crossbar itself,
   // so they do not wait for a device rvalid.
   // ---------------------------------------------------------------------------
   logic                    resp_valid;
   logic [DataWidth-1:0]    resp_rdata;
   logic                    resp_err;

   assign resp_valid = resp_pending && (resp_unmapped || bus.device_rvalid_i[resp_dev]);
   assign resp_rdata = resp_unmapped ? '0   : bus.device_rdata_i[resp_dev];
   assign resp_err   = resp_unmapped ? 1'b1 : bus.device_err_i[resp_dev];

   always_comb begin
      bus.host_rvalid_o = '0;
      bus.host_rdata_o  = '0;
      bus.host_err_o    = '0;
      for (int h = 0; h < NrHosts; h++) begin
         bus.host_rvalid_o[h] = resp_valid && (resp_host == HostIdxW'(h));
         bus.host_rdata_o[h]  = resp_rdata;
         bus.host_err_o[h]    = resp_err;
      end
   end

endmodule

// File: tb/tb_simple_bus_xbar.sv
// -----------------------------------------------------------------------------
// tb_simple_bus_xbar
// Directed, table-driven bench for simple_bus_xbar with 2 hosts and 3 devices
// on the reference address map. Each table row is one clock cycle: inputs are
// driven on the falling edge, outputs compared shortly after. Host 1 stays idle
// except in the arbitration rows, so those rows behave like a 1-host system.
// -----------------------------------------------------------------------------
module tb_simple_bus_xbar;

   localparam int unsigned NH = 2;
   localparam int unsigned ND = 3;

   logic clk_i;
   logic rst_ni;

   simple_bus_xbar_if #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) bus ();

   simple_bus_xbar #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      // stimulus
      logic [1:0]        req;
      logic [1:0][31:0]  addr;
      logic              we;
      logic [3:0]        be;
      logic [31:0]       wdata;
      logic [2:0]        drv;
      logic [2:0][31:0]  drd;
      logic [2:0]        derr;
      // expected
      logic [1:0]        gnt;
      logic [2:0]        dreq;
      logic [31:0]       daddr;
      logic [1:0]        rvalid;
      logic [31:0]       rdata;
      logic              err;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
      input logic we, input logic [3:0] be, input logic [31:0] wd,
      input logic [2:0] drv, input logic [31:0] d0, input logic [31:0] d1,
      input logic [31:0] d2, input logic [2:0] derr,
      input logic [1:0] gnt, input logic [2:0] dreq, input logic [31:0] daddr,
      input logic [1:0] rv, input logic [31:0] rd, input logic err);
      vec_t v;
      v.req = req;  v.addr[0] = a0; v.addr[1] = a1;
      v.we = we;    v.be = be;      v.wdata = wd;
      v.drv = drv;  v.drd[0] = d0;  v.drd[1] = d1; v.drd[2] = d2; v.derr = derr;
      v.gnt = gnt;  v.dreq = dreq;  v.daddr = daddr;
      v.rvalid = rv; v.rdata = rd;  v.err = err;
      return v;
   endfunction

   task automatic drive_idle();
      bus.host_req_i      = '0;
      bus.host_addr_i     = '0;
      bus.host_we_i       = '0;
      bus.host_be_i       = '0;
      bus.host_wdata_i    = '0;
      bus.device_rvalid_i = '0;
      bus.device_rdata_i  = '0;
      bus.device_err_i    = '0;
   endtask

   vec_t vecs[16];

   initial begin
      //              req    a0            a1            we   be    wdata         drv     d0            d1            d2            derr    gnt    dreq    daddr         rv     rdata         err
      vecs[0]  = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b00, 3'b000, 32'h0,        2'b00, 32'h0,        1'b0);
      // write to dev0
      vecs[1]  = mk(2'b01, 32'h0100_0010,32'h0,        1'b1,4'hF,32'hDEAD_BEEF,3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b01, 3'b001, 32'h0100_0010,2'b00, 32'h0,        1'b0);
      // read dev1 issued while the write completes
      vecs[2]  = mk(2'b01, 32'h0002_0004,32'h0,        1'b0,4'hF,32'h0,        3'b001, 32'h0,        32'h0,        32'h0,        3'b000, 2'b01, 3'b010, 32'h0002_0004,2'b01, 32'h0,        1'b0);
      vecs[3]  = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b010, 32'h0,        32'h1234_5678,32'h0,        3'b000, 2'b00, 3'b000, 32'h0,        2'b01, 32'h1234_5678,1'b0);
      // unmapped read
      vecs[4]  = mk(2'b01, 32'h0004_0000,32'h0,        1'b0,4'hF,32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b01, 3'b000, 32'h0004_0000,2'b00, 32'h0,        1'b0);
      vecs[5]  = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b000, 32'hAAAA_AAAA,32'hBBBB_BBBB,32'h0,        3'b000, 2'b00, 3'b000, 32'h0,        2'b01, 32'h0,        1'b1);
      // back-to-back dev0, dev2 (err), dev0
      vecs[6]  = mk(2'b01, 32'h0100_0020,32'h0,        1'b0,4'hF,32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b01, 3'b001, 32'h0100_0020,2'b00, 32'h0,        1'b0);
      vecs[7]  = mk(2'b01, 32'h0003_0008,32'h0,        1'b0,4'hF,32'h0,        3'b001, 32'h1111_1111,32'h0,        32'h0,        3'b000, 2'b01, 3'b100, 32'h0003_0008,2'b01, 32'h1111_1111,1'b0);
      vecs[8]  = mk(2'b01, 32'h0100_0030,32'h0,        1'b0,4'hF,32'h0,        3'b100, 32'h0000_0099,32'h0,        32'h2222_2222,3'b100, 2'b01, 3'b001, 32'h0100_0030,2'b01, 32'h2222_2222,1'b1);
      vecs[9]  = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b001, 32'h3333_3333,32'h0,        32'h0,        3'b100, 2'b00, 3'b000, 32'h0,        2'b01, 32'h3333_3333,1'b0);
      // both hosts request dev0
      vecs[10] = mk(2'b11, 32'h0100_0040,32'h0100_0050,1'b0,4'hF,32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b01, 3'b001, 32'h0100_0040,2'b00, 32'h0,        1'b0);
      vecs[11] = mk(2'b10, 32'h0,        32'h0100_0050,1'b0,4'hF,32'h0,        3'b001, 32'h4444_4444,32'h0,        32'h0,        3'b000, 2'b10, 3'b001, 32'h0100_0050,2'b01, 32'h4444_4444,1'b0);
      vecs[12] = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b001, 32'h5555_5555,32'h0,        32'h0,        3'b000, 2'b00, 3'b000, 32'h0,        2'b10, 32'h5555_5555,1'b0);
      // stray device rvalid with nothing pending
      vecs[13] = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b001, 32'h0000_0066,32'h0,        32'h0,        3'b000, 2'b00, 3'b000, 32'h0,        2'b00, 32'h0,        1'b0);
      // pending but device silent
      vecs[14] = mk(2'b01, 32'h0002_0000,32'h0,        1'b0,4'hF,32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b01, 3'b010, 32'h0002_0000,2'b00, 32'h0,        1'b0);
      vecs[15] = mk(2'b00, 32'h0,        32'h0,        1'b0,4'h0,32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 2'b00, 3'b000, 32'h0,        2'b00, 32'h0,        1'b0);

      // ------------------------------------------------------------ reset state
      rst_ni = 1'b0;
      drive_idle();
      bus.device_rdata_i[0] = 32'hCAFE_0000;
      bus.cfg_device_addr_base[0] = 32'h0100_0000; bus.cfg_device_addr_mask[0] = 32'hFF00_0000;
      bus.cfg_device_addr_base[1] = 32'h0002_0000; bus.cfg_device_addr_mask[1] = 32'hFFFF_FC00;
      bus.cfg_device_addr_base[2] = 32'h0003_0000; bus.cfg_device_addr_mask[2] = 32'hFFFF_FC00;
      #2;
      chk("rst_gnt",    128'(bus.host_gnt_o),    128'(2'b00));
      chk("rst_dreq",   128'(bus.device_req_o),  128'(3'b000));
      chk("rst_rvalid", 128'(bus.host_rvalid_o), 128'(2'b00));
      chk("rst_err",    128'(bus.host_err_o),    128'(2'b00));
      chk("rst_rdata",  128'(bus.host_rdata_o[0]), 128'(32'hCAFE_0000));

      @(negedge clk_i);
      rst_ni = 1'b1;

      // ------------------------------------------------------------ table
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         bus.host_req_i      = vecs[i].req;
         bus.host_addr_i     = vecs[i].addr;
         bus.host_we_i       = {2{vecs[i].we}};
         bus.host_be_i       = {2{vecs[i].be}};
         bus.host_wdata_i    = {2{vecs[i].wdata}};
         bus.device_rvalid_i = vecs[i].drv;
         bus.device_rdata_i  = vecs[i].drd;
         bus.device_err_i    = vecs[i].derr;
         #2;
         chk($sformatf("v%0d_gnt", i),    128'(bus.host_gnt_o),    128'(vecs[i].gnt));
         chk($sformatf("v%0d_dreq", i),   128'(bus.device_req_o),  128'(vecs[i].dreq));
         chk($sformatf("v%0d_rvalid", i), 128'(bus.host_rvalid_o), 128'(vecs[i].rvalid));
         if (vecs[i].dreq != 3'b000) begin
            chk($sformatf("v%0d_daddr", i), 128'(bus.device_addr_o),  128'({3{vecs[i].daddr}}));
            chk($sformatf("v%0d_dwe", i),   128'(bus.device_we_o),    128'({3{vecs[i].we}}));
            chk($sformatf("v%0d_dbe", i),   128'(bus.device_be_o),    128'({3{vecs[i].be}}));
            chk($sformatf("v%0d_dwd", i),   128'(bus.device_wdata_o), 128'({3{vecs[i].wdata}}));
         end
         if (vecs[i].rvalid != 2'b00) begin
            chk($sformatf("v%0d_rdata", i), 128'(bus.host_rdata_o), 128'({2{vecs[i].rdata}}));
            chk($sformatf("v%0d_err", i),   128'(bus.host_err_o),   128'({2{vecs[i].err}}));
         end
      end

      // ------------------------------------------------------------ reset mid-transaction
      @(negedge clk_i);
      drive_idle();
      bus.host_req_i[0]  = 1'b1;
      bus.host_addr_i[0] = 32'h0100_0000;
      #2;
      chk("mid_gnt",  128'(bus.host_gnt_o),   128'(2'b01));
      chk("mid_dreq", 128'(bus.device_req_o), 128'(3'b001));
      @(posedge clk_i);
      #2;
      // response would be due now; reset drops it
      bus.host_req_i      = '0;
      bus.device_rvalid_i = 3'b001;
      bus.device_rdata_i[0] = 32'h7777_7777;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_rvalid", 128'(bus.host_rvalid_o), 128'(2'b00));
      chk("mid_rst_gnt",    128'(bus.host_gnt_o),    128'(2'b00));
      chk("mid_rst_dreq",   128'(bus.device_req_o),  128'(3'b000));
      chk("mid_rst_err",    128'(bus.host_err_o),    128'(2'b00));
      @(negedge clk_i);
      rst_ni = 1'b1;
      #2;
      chk("post_rst_rvalid0", 128'(bus.host_rvalid_o), 128'(2'b00));
      @(negedge clk_i);
      #2;
      chk("post_rst_rvalid1", 128'(bus.host_rvalid_o), 128'(2'b00));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
